// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// The ovf result line exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b,
`ifdef SERIAL_SUB_OVF_EN
    input  ovf,
`endif
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b,
`ifdef SERIAL_SUB_OVF_EN
    output ovf,
`endif
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B using one full-adder cell (B inverted, carry seeded to 1), LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             load, step, finish, last;
  logic             s, cy;
`ifdef SERIAL_SUB_OVF_EN
  logic             carry_msb_in;
`endif

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // The single full-adder cell: a + ~b + carry.
  assign s  = a_sh[0] ^ ~b_sh[0] ^ carry;
  assign cy = (a_sh[0] & ~b_sh[0]) | (a_sh[0] & carry) | (~b_sh[0] & carry);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: if (bus.start) begin
        load      = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        step = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        finish    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.diff <= '0;
      bus.bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      carry_msb_in <= 1'b0;
      bus.ovf      <= 1'b0;
`endif
    end else begin
      bus.done <= finish;
      if (load) begin
        a_sh     <= bus.a;
        b_sh     <= bus.b;
        carry    <= 1'b1;
        cnt      <= '0;
        bus.busy <= 1'b1;
      end
      if (step) begin
        r_sh  <= {s, r_sh[WIDTH-1:1]};
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        carry <= cy;
        cnt   <= cnt + 1'b1;
`ifdef SERIAL_SUB_OVF_EN
        // Carry entering the MSB cell is the carry held during the final bit.
        if (last) carry_msb_in <= carry;
`endif
      end
      if (finish) begin
        bus.busy <= 1'b0;
        bus.diff <= r_sh;
        bus.bout <= ~carry;
`ifdef SERIAL_SUB_OVF_EN
        bus.ovf  <= carry_msb_in ^ carry;
`endif
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus random operands
// compared against an arithmetic reference model (ovf checked when SERIAL_SUB_OVF_EN is defined).
module tb_serial_subtractor;
  localparam int WIDTH   = 16;
  localparam int LAT     = WIDTH + 1;
  localparam int TIMEOUT = 4 * WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();
  serial_subtractor #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain unsigned/signed arithmetic on the operands.
  function automatic logic [WIDTH-1:0] m_diff(input logic [WIDTH-1:0] a, b);
    return a - b;
  endfunction

  function automatic logic m_bout(input logic [WIDTH-1:0] a, b);
    return a < b;
  endfunction

  function automatic logic m_ovf(input logic [WIDTH-1:0] a, b);
    longint sa, sb, d;
    sa = a[WIDTH-1] ? longint'(a) - (longint'(1) << WIDTH) : longint'(a);
    sb = b[WIDTH-1] ? longint'(b) - (longint'(1) << WIDTH) : longint'(b);
    d  = sa - sb;
    return (d > (longint'(1) << (WIDTH - 1)) - 1) || (d < -(longint'(1) << (WIDTH - 1)));
  endfunction

  task automatic check_result(input string tag, input logic [WIDTH-1:0] a, b);
    check({tag, ".diff"}, 32'(bus.diff), 32'(m_diff(a, b)));
    check({tag, ".bout"}, 32'(bus.bout), 32'(m_bout(a, b)));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, ".ovf"}, 32'(bus.ovf), 32'(m_ovf(a, b)));
`endif
  endtask

  // Pulse start for one edge, then wait (bounded) for done and check everything.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, b);
    int n;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    check({tag, ".busy_after_accept"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.done && n < TIMEOUT) begin
      tick();
      n++;
      if (!bus.done && n < LAT && bus.diff !== '0 && tag == "t1")
        check({tag, ".diff_stable"}, 32'(bus.diff), 32'd0);
    end
    check({tag, ".latency"}, 32'(n), 32'(LAT));
    check({tag, ".busy_at_done"}, 32'(bus.busy), 32'd0);
    check_result(tag, a, b);
    tick();
    check({tag, ".done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int dones, first_at, gap, n;
    logic [WIDTH-1:0] ra, rb;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.done", 32'(bus.done), 32'd0);
    check("reset.diff", 32'(bus.diff), 32'd0);
    check("reset.bout", 32'(bus.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset.ovf", 32'(bus.ovf), 32'd0);
`endif

    // Directed basics and boundaries.
    run_op("t1", 16'h1234, 16'h0034);
    run_op("t2a", 16'h0000, 16'h0001);
    run_op("t2b", 16'hFFFF, 16'hFFFF);
    run_op("ovf_a", 16'h8000, 16'h0001);
    run_op("ovf_b", 16'h7FFF, 16'hFFFF);
    run_op("ovf_c", 16'h0003, 16'h0005);

    // A start request during RUN must be ignored.
    bus.start = 1'b1; bus.a = 16'h0005; bus.b = 16'h0003;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'h0000;
    tick();
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 3 * WIDTH; i++) begin
      if (bus.done) begin
        dones++;
        check("t3.diff", 32'(bus.diff), 32'h0002);
      end
      tick();
    end
    check("t3.done_count", 32'(dones), 32'd1);
    check("t3.busy_after", 32'(bus.busy), 32'd0);

    // Synchronous reset mid-operation aborts without a done pulse.
    bus.start = 1'b1; bus.a = 16'h00FF; bus.b = 16'h0001;
    tick();
    bus.start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4.busy", 32'(bus.busy), 32'd0);
    check("t4.diff", 32'(bus.diff), 32'd0);
    check("t4.bout", 32'(bus.bout), 32'd0);
    dones = 0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      if (bus.done) dones++;
      tick();
    end
    check("t4.no_done", 32'(dones), 32'd0);
    run_op("t4b", 16'h0010, 16'h0010);

    // start held high: back-to-back operations every WIDTH+2 cycles.
    bus.start = 1'b1; bus.a = 16'h0003; bus.b = 16'h0001;
    dones = 0; first_at = -1; gap = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.done) begin
        dones++;
        check("t5.diff", 32'(bus.diff), 32'h0002);
        if (first_at < 0) first_at = i;
        else if (gap < 0) gap = i - first_at;
      end
    end
    bus.start = 1'b0;
    check("t5.done_count", 32'(dones), 32'd2);
    check("t5.gap", 32'(gap), 32'(WIDTH + 2));
    // Drain the operation still in flight.
    n = 0;
    while (!bus.done && n < TIMEOUT) begin
      tick();
      n++;
    end
    check("t5.drain", 32'(n < TIMEOUT), 32'd1);
    tick();

    // Random operands against the reference model.
    for (int i = 0; i < 30; i++) begin
      ra = WIDTH'($urandom);
      rb = (i % 5 == 0) ? ra : WIDTH'($urandom);
      run_op($sformatf("rnd%0d", i), ra, rb);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
